// File: rtl/mash_cfg_pkg.sv
// Shared types and defaults for the MASH configuration controller.
// State encoding, default parameters and the settle counter width.
package mash_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_SEED_W     = 12;
    localparam int DEF_ACC_W      = 8;
    localparam int DEF_MBIT_W     = 4;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int CNT_W          = 8;

endpackage

// File: rtl/mash_sel_decode.sv
// Clamps the accumulator bit count and builds sum/carry select masks.
// Purely combinational; the parent registers the results.
module mash_sel_decode
    import mash_cfg_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int MBIT_W = DEF_MBIT_W
) (
    input  logic [MBIT_W-1:0] mash_bit,
    output logic [MBIT_W-1:0] n,
    output logic [ACC_W-1:0]  sum_sel,
    output logic [ACC_W:0]    cout_sel
);

    localparam logic [MBIT_W-1:0] N_MAX = MBIT_W'(ACC_W);

    always_comb begin
        n        = (mash_bit > N_MAX) ? N_MAX : mash_bit;
        sum_sel  = '0;
        cout_sel = '0;
        for (int i = 0; i < ACC_W; i++) begin
            sum_sel[i] = (i < int'(n));
        end
        for (int i = 0; i <= ACC_W; i++) begin
            cout_sel[i] = (i == int'(n));
        end
    end

endmodule

// File: rtl/mash_cfg_ctrl.sv
// MASH configuration controller: shadow capture, tick-aligned atomic
// apply, and a clear/settle window after structural changes.
module mash_cfg_ctrl
    import mash_cfg_pkg::*;
#(
    parameter int SEED_W     = DEF_SEED_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int MBIT_W     = DEF_MBIT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_req,
    input  logic              i_tick,
    input  logic [SEED_W-1:0] i_seed,
    input  logic [1:0]        i_sel_order,
    input  logic [MBIT_W-1:0] i_mash_bit,
    input  logic              i_mashreseten,
    input  logic              i_phaseadjusten,
    input  logic              i_sel_frac,
    output logic [SEED_W-1:0] o_seed,
    output logic [1:0]        o_sel_order,
    output logic [ACC_W-1:0]  o_sum_sel,
    output logic [ACC_W:0]    o_cout_sel,
    output logic              o_mashreseten,
    output logic              o_phaseadjusten,
    output logic              o_sel_frac,
    output logic              o_mash_clr,
    output logic              o_busy,
    output logic              o_cfg_ack,
    output logic              o_cfg_err
);

    localparam logic [MBIT_W-1:0] N_MAX    = MBIT_W'(ACC_W);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [SEED_W-1:0]   sh_seed;
    logic [1:0]          sh_order;
    logic [MBIT_W-1:0]   sh_mbit;
    logic                sh_mrst;
    logic                sh_padj;
    logic                sh_frac;
    logic [MBIT_W-1:0]   act_n;
    logic [MBIT_W-1:0]   dec_n;
    logic [ACC_W-1:0]    dec_sum;
    logic [ACC_W:0]      dec_cout;
    logic                accept;
    logic                apply;
    logic                structural;

    mash_sel_decode #(
        .ACC_W  (ACC_W),
        .MBIT_W (MBIT_W)
    ) u_dec (
        .mash_bit (sh_mbit),
        .n        (dec_n),
        .sum_sel  (dec_sum),
        .cout_sel (dec_cout)
    );

    assign accept     = (state_q == ST_IDLE) && i_cfg_req;
    assign apply      = (state_q == ST_PEND) && i_tick;
    assign structural = (sh_order != o_sel_order) || (dec_n != act_n) || sh_mrst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (i_cfg_req) state_d = ST_PEND;
            ST_PEND:   if (i_tick) state_d = structural ? ST_SETTLE : ST_DONE;
            ST_SETTLE: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mash_clr = (state_q == ST_SETTLE);
        o_busy     = (state_q != ST_IDLE);
        o_cfg_ack  = (state_q == ST_DONE);
    end

    // Shadow, active bank and settle counter share one register process.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sh_seed         <= '0;
            sh_order        <= '0;
            sh_mbit         <= '0;
            sh_mrst         <= 1'b0;
            sh_padj         <= 1'b0;
            sh_frac         <= 1'b0;
            o_cfg_err       <= 1'b0;
            o_seed          <= '0;
            o_sel_order     <= '0;
            o_sum_sel       <= '0;
            o_cout_sel      <= '0;
            o_mashreseten   <= 1'b0;
            o_phaseadjusten <= 1'b0;
            o_sel_frac      <= 1'b0;
            act_n           <= '0;
            cnt_q           <= '0;
        end else begin
            if (accept) begin
                sh_seed   <= i_seed;
                sh_order  <= i_sel_order;
                sh_mbit   <= i_mash_bit;
                sh_mrst   <= i_mashreseten;
                sh_padj   <= i_phaseadjusten;
                sh_frac   <= i_sel_frac;
                o_cfg_err <= (i_mash_bit > N_MAX);
            end
            if (apply) begin
                o_seed          <= sh_seed;
                o_sel_order     <= sh_order;
                o_sum_sel       <= dec_sum;
                o_cout_sel      <= dec_cout;
                o_mashreseten   <= sh_mrst;
                o_phaseadjusten <= sh_padj;
                o_sel_frac      <= sh_frac;
                act_n           <= dec_n;
                cnt_q           <= CNT_LOAD;
            end else if (state_q == ST_SETTLE && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mash_cfg_ctrl.sv
// Self-checking bench for mash_cfg_ctrl with a behavioural model.
// Directed steps followed by randomized request/tick sequences.
module tb_mash_cfg_ctrl;

    localparam int SEED_W = 12;
    localparam int ACC_W  = 8;
    localparam int MBIT_W = 4;
    localparam int SETTLE = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_cfg_req = 1'b0;
    logic              i_tick = 1'b0;
    logic [SEED_W-1:0] i_seed = '0;
    logic [1:0]        i_sel_order = '0;
    logic [MBIT_W-1:0] i_mash_bit = '0;
    logic              i_mashreseten = 1'b0;
    logic              i_phaseadjusten = 1'b0;
    logic              i_sel_frac = 1'b0;
    logic [SEED_W-1:0] o_seed;
    logic [1:0]        o_sel_order;
    logic [ACC_W-1:0]  o_sum_sel;
    logic [ACC_W:0]    o_cout_sel;
    logic              o_mashreseten;
    logic              o_phaseadjusten;
    logic              o_sel_frac;
    logic              o_mash_clr;
    logic              o_busy;
    logic              o_cfg_ack;
    logic              o_cfg_err;

    int total = 0;
    int bad   = 0;

    // Reference model: shadow and active configuration as plain integers
    int m_sh_seed, m_sh_order, m_sh_mbit, m_sh_mrst, m_sh_padj, m_sh_frac;
    int m_seed, m_order, m_n, m_mrst, m_padj, m_frac;
    int m_applied, m_err;

    mash_cfg_ctrl #(
        .SEED_W     (SEED_W),
        .ACC_W      (ACC_W),
        .MBIT_W     (MBIT_W),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_cfg_req       (i_cfg_req),
        .i_tick          (i_tick),
        .i_seed          (i_seed),
        .i_sel_order     (i_sel_order),
        .i_mash_bit      (i_mash_bit),
        .i_mashreseten   (i_mashreseten),
        .i_phaseadjusten (i_phaseadjusten),
        .i_sel_frac      (i_sel_frac),
        .o_seed          (o_seed),
        .o_sel_order     (o_sel_order),
        .o_sum_sel       (o_sum_sel),
        .o_cout_sel      (o_cout_sel),
        .o_mashreseten   (o_mashreseten),
        .o_phaseadjusten (o_phaseadjusten),
        .o_sel_frac      (o_sel_frac),
        .o_mash_clr      (o_mash_clr),
        .o_busy          (o_busy),
        .o_cfg_ack       (o_cfg_ack),
        .o_cfg_err       (o_cfg_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic int clamp_n(input int m);
        return (m > ACC_W) ? ACC_W : m;
    endfunction

    task automatic model_reset();
        m_sh_seed = 0; m_sh_order = 0; m_sh_mbit = 0;
        m_sh_mrst = 0; m_sh_padj = 0; m_sh_frac = 0;
        m_seed = 0; m_order = 0; m_n = 0;
        m_mrst = 0; m_padj = 0; m_frac = 0;
        m_applied = 0; m_err = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int sum_e, cout_e;
        sum_e  = m_applied ? (((1 << m_n) - 1) & ((1 << ACC_W) - 1)) : 0;
        cout_e = m_applied ? (1 << m_n) : 0;
        chk({tag, "_seed"}, 32'(o_seed), m_seed);
        chk({tag, "_order"}, 32'(o_sel_order), m_order);
        chk({tag, "_sum"}, 32'(o_sum_sel), sum_e);
        chk({tag, "_cout"}, 32'(o_cout_sel), cout_e);
        chk({tag, "_ctl"}, {29'd0, o_mashreseten, o_phaseadjusten, o_sel_frac},
            (m_mrst << 2) | (m_padj << 1) | m_frac);
        chk({tag, "_err"}, 32'(o_cfg_err), m_err);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input int seed, input int order, input int mbit,
                         input int mrst, input int padj, input int frac);
        i_seed          = SEED_W'(seed);
        i_sel_order     = 2'(order);
        i_mash_bit      = MBIT_W'(mbit);
        i_mashreseten   = 1'(mrst);
        i_phaseadjusten = 1'(padj);
        i_sel_frac      = 1'(frac);
    endtask

    // Request accepted from IDLE; optional same-cycle tick must be ignored
    task automatic req(input int seed, input int order, input int mbit,
                       input int mrst, input int padj, input int frac,
                       input bit with_tick);
        drive(seed, order, mbit, mrst, padj, frac);
        i_cfg_req = 1'b1;
        i_tick    = with_tick;
        step();
        i_cfg_req = 1'b0;
        i_tick    = 1'b0;
        m_sh_seed = seed; m_sh_order = order; m_sh_mbit = mbit;
        m_sh_mrst = mrst; m_sh_padj = padj; m_sh_frac = frac;
        m_err = (mbit > ACC_W);
        chk("req_busy", 32'(o_busy), 1);
        chk("req_ack", 32'(o_cfg_ack), 0);
        chk_all("req");
    endtask

    // Tick in PEND, then follow the settle window and ack pulse
    task automatic apply_tick();
        int changed;
        changed = (m_sh_order != m_order) || (clamp_n(m_sh_mbit) != m_n)
                  || m_sh_mrst;
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        m_seed = m_sh_seed; m_order = m_sh_order; m_n = clamp_n(m_sh_mbit);
        m_mrst = m_sh_mrst; m_padj = m_sh_padj; m_frac = m_sh_frac;
        m_applied = 1;
        chk_all("apply");
        if (changed != 0) begin
            for (int k = 0; k < SETTLE; k++) begin
                chk("settle_clr", 32'(o_mash_clr), 1);
                chk("settle_ack", 32'(o_cfg_ack), 0);
                chk("settle_busy", 32'(o_busy), 1);
                step();
            end
        end
        chk("done_ack", 32'(o_cfg_ack), 1);
        chk("done_clr", 32'(o_mash_clr), 0);
        chk("done_busy", 32'(o_busy), 1);
        step();
        chk("idle_ack", 32'(o_cfg_ack), 0);
        chk("idle_busy", 32'(o_busy), 0);
        chk_all("idle");
    endtask

    initial begin
        model_reset();
        step();
        step();
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_clr", 32'(o_mash_clr), 0);
        chk("rst_ack", 32'(o_cfg_ack), 0);
        chk_all("rst");
        i_rst = 1'b0;
        step();
        chk_all("post_rst");

        // Structural change: order and width from reset values
        req(12'hA5A, 3, 5, 0, 0, 0, 1'b0);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        chk("t1_sum", 32'(o_sum_sel), 32'h1F);
        chk("t1_cout", 32'(o_cout_sel), 32'h020);
        chk("t1_seed", 32'(o_seed), 32'hA5A);
        for (int k = 0; k < SETTLE; k++) begin
            chk("t1_clr", 32'(o_mash_clr), 1);
            step();
        end
        chk("t1_ack", 32'(o_cfg_ack), 1);
        chk("t1_clr_end", 32'(o_mash_clr), 0);
        step();
        chk("t1_idle", 32'(o_busy), 0);
        m_seed = 12'hA5A; m_order = 3; m_n = 5; m_applied = 1;
        chk_all("t1");

        // Seed-only change: no clear window
        req(12'h123, 3, 5, 0, 0, 0, 1'b0);
        apply_tick();
        chk("t2_seed", 32'(o_seed), 32'h123);

        // Out-of-range width clamps and flags error
        req(12'h0F0, 3, 12, 0, 1, 1, 1'b0);
        chk("t3_err", 32'(o_cfg_err), 1);
        apply_tick();
        chk("t3_sum", 32'(o_sum_sel), 32'hFF);
        chk("t3_cout", 32'(o_cout_sel), 32'h100);
        req(12'h0F1, 3, 8, 0, 0, 0, 1'b0);
        chk("t3_err_clr", 32'(o_cfg_err), 0);
        apply_tick();

        // Held in PEND; second request must be ignored
        req(12'h3C3, 1, 2, 0, 0, 1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                drive(12'h777, 2, 6, 1, 1, 0);
                i_cfg_req = 1'b1;
            end
            step();
            i_cfg_req = 1'b0;
            chk("t4_busy", 32'(o_busy), 1);
            chk_all("t4_hold");
        end
        apply_tick();
        chk("t4_seed", 32'(o_seed), 32'h3C3);

        // Reset during settle with the counter at 2
        req(12'h555, 2, 7, 0, 0, 0, 1'b0);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        chk("t5_clr", 32'(o_mash_clr), 1);
        step();
        i_rst = 1'b1;
        #1;
        model_reset();
        chk("t5_busy", 32'(o_busy), 0);
        chk("t5_clr0", 32'(o_mash_clr), 0);
        chk("t5_ack0", 32'(o_cfg_ack), 0);
        chk_all("t5_rst");
        #2;
        i_rst = 1'b0;
        for (int k = 0; k < SETTLE + 2; k++) begin
            step();
            chk("t5_no_ack", 32'(o_cfg_ack), 0);
            chk("t5_idle", 32'(o_busy), 0);
        end
        chk_all("t5_after");

        // Width sweep
        for (int m = 0; m <= ACC_W; m++) begin
            req(16 * m + 1, 0, m, 0, 0, 0, 1'b0);
            apply_tick();
        end

        // Randomized requests, delays, stray ticks and ignored requests
        for (int it = 0; it < 30; it++) begin
            int seed, order, mbit, mrst, dly;
            if ($urandom_range(0, 2) == 0) begin
                i_tick = 1'b1;
                step();
                i_tick = 1'b0;
                chk_all("rnd_idle_tick");
            end
            seed  = int'($urandom_range(0, 4095));
            order = ($urandom_range(0, 1) != 0) ? m_sh_order
                                                : int'($urandom_range(0, 3));
            mbit  = ($urandom_range(0, 1) != 0) ? m_sh_mbit
                                                : int'($urandom_range(0, 15));
            mrst  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            req(seed, order, mbit, mrst, int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            dly = int'($urandom_range(0, 3));
            for (int k = 0; k < dly; k++) begin
                if ($urandom_range(0, 1) != 0) begin
                    drive(int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)), 1, 1, 1);
                    i_cfg_req = 1'b1;
                end
                step();
                i_cfg_req = 1'b0;
                chk("rnd_busy", 32'(o_busy), 1);
                chk_all("rnd_hold");
            end
            apply_tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
